btn_debounce: RTL and testbench

Push-button front end for the LED blink stage. It synchronises a raw board button and debounces it with a counter-based filter. It then emits a clean level plus single-cycle press, release and long-press strobes, and keeps a wrapping press counter. The blink controller downstream consumes these strobes to select its on/off periods.

---
 rtl/btn_debounce_if.sv | 31 +++
 rtl/btn_debounce.sv | 181 ++++++++++++++++++
 tb/tb_btn_debounce.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/btn_debounce_if.sv
// btn_debounce_if
// Bundles the raw button input with the debounced outputs of btn_debounce.
// master: the debouncer (consumes btn_in, drives level/strobes/count).
// slave : the board side and the downstream blink controller.

interface btn_debounce_if;
    logic       btn_in;
    logic       btn_level;
    logic       press_pulse;
    logic       release_pulse;
    logic       long_pulse;
    logic [7:0] press_count;

    modport master (
        input  btn_in,
        output btn_level,
        output press_pulse,
        output release_pulse,
        output long_pulse,
        output press_count
    );

    modport slave (
        output btn_in,
        input  btn_level,
        input  press_pulse,
        input  release_pulse,
        input  long_pulse,
        input  press_count
    );
endinterface

// File: rtl/btn_debounce.sv
// btn_debounce
// Push-button front end: two-flop synchroniser, counter-based debounce FSM,
// registered press/release strobes and a wrapping 8-bit press counter.
//
// Optional feature, macro LONG_PRESS_EN:
//   defined   -> hold timer plus a one-shot long_pulse LONG_CYCLES cycles
//                after an accepted press (if the button is still held).
//   undefined -> no hold timer, long_pulse tied low, LONG_CYCLES unused.

module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LONG_CYCLES     = 50000000
) (
    input  logic             clk,
    input  logic             rst_n,
    btn_debounce_if.master   bus
);

    // Elaboration-time guards on the parameter ranges.
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("btn_debounce: DEBOUNCE_CYCLES must be >= 1");
    end
    if (LONG_CYCLES < 1) begin : g_bad_long
        $error("btn_debounce: LONG_CYCLES must be >= 1");
    end

    localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,  // released and stable
        PRESS_WAIT   = 2'd1,  // saw a 1, counting stable 1 samples
        HELD         = 2'd2,  // pressed and stable
        RELEASE_WAIT = 2'd3   // saw a 0, counting stable 0 samples
    } state_t;

    logic             sync1;
    logic             btn_sync;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             level_q;
    logic             press_q;
    logic             release_q;
    logic [7:0]       count_q;

    // The edges on which the filter accepts a level change. Shared by the
    // FSM and the hold timer so both agree on the same cycle.
    logic press_accept;
    logic release_accept;

    assign press_accept   = (state == PRESS_WAIT)   &&  btn_sync && (cnt == CNT_MAX);
    assign release_accept = (state == RELEASE_WAIT) && !btn_sync && (cnt == CNT_MAX);

    // Two-flop synchroniser for the asynchronous button input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= 1'b0;
            btn_sync <= 1'b0;
        end else begin
            // NOTE: non-blocking so btn_sync takes sync1's previous value,
            // giving two real flop stages rather than one.
            sync1    <= bus.btn_in;
            btn_sync <= sync1;
        end
    end

    // Debounce FSM with registered level, strobes and press counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            count_q   <= 8'd0;
        end else begin
            // Strobes are single-cycle unless re-armed below.
            press_q   <= 1'b0;
            release_q <= 1'b0;

            case (state)
                IDLE: begin
                    if (btn_sync) begin
                        state <= PRESS_WAIT;
                        cnt   <= CNT_ONE;
                    end else begin
                        cnt   <= '0;
                    end
                end

                PRESS_WAIT: begin
                    if (!btn_sync) begin
                        // Glitch: drop back without any strobe.
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (press_accept) begin
                        state   <= HELD;
                        cnt     <= '0;
                        level_q <= 1'b1;
                        press_q <= 1'b1;
                        count_q <= count_q + 8'd1;  // wraps 255 -> 0
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                HELD: begin
                    if (!btn_sync) begin
                        state <= RELEASE_WAIT;
                        cnt   <= CNT_ONE;
                    end else begin
                        cnt   <= '0;
                    end
                end

                RELEASE_WAIT: begin
                    if (btn_sync) begin
                        // Release bounce: back to HELD, no strobe.
                        state <= HELD;
                        cnt   <= '0;
                    end else if (release_accept) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        level_q   <= 1'b0;
                        release_q <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef LONG_PRESS_EN
    localparam int                 HOLD_W    = $clog2(LONG_CYCLES + 1);
    localparam logic [HOLD_W-1:0]  HOLD_MAX  = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0]  HOLD_ONE  = HOLD_W'(1);

    logic [HOLD_W-1:0] hold_timer;
    logic              long_q;
    logic              pressed_state;

    assign pressed_state = (state == HELD) || (state == RELEASE_WAIT);

    // Hold timer: cleared on an accepted press, counts while pressed
    // (including release bounces) and saturates, so long_pulse is one-shot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_timer <= '0;
            long_q     <= 1'b0;
        end else begin
            long_q <= 1'b0;
            if (press_accept) begin
                hold_timer <= '0;
            end else if (pressed_state && (hold_timer != HOLD_MAX)) begin
                hold_timer <= hold_timer + HOLD_ONE;
                if (hold_timer == HOLD_LAST) begin
                    long_q <= 1'b1;
                end
            end
        end
    end

    assign bus.long_pulse = long_q;
`else
    assign bus.long_pulse = 1'b0;
`endif

    assign bus.btn_level     = level_q;
    assign bus.press_pulse   = press_q;
    assign bus.release_pulse = release_q;
    assign bus.press_count   = count_q;

endmodule

// File: tb/tb_btn_debounce.sv
// tb_btn_debounce
// Directed scenarios plus randomized button activity, checked every cycle
// against a history-based reference model: a level change is accepted once
// the last DEB+1 synchronised samples all differ from the current level.

module tb_btn_debounce;

    localparam int DEB  = 4;
    localparam int LONG = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    btn_debounce_if bus();

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEB),
        .LONG_CYCLES    (LONG)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Reference model state.
    bit         hq[$];       // btn_in value sampled at each edge since reset
    bit         m_level;
    bit         m_press;
    bit         m_rel;
    bit         m_long;
    logic [7:0] m_count;
    int         n_edge = 0;
    int         last_press;

    // Observations used by the directed latency checks.
    int seen_press;
    int seen_release;
    int seen_long;
    int long_hits;
    bit wrap_seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, n_edge);
        end
    endtask

    task automatic model_reset();
        hq.delete();
        m_level    = 1'b0;
        m_press    = 1'b0;
        m_rel      = 1'b0;
        m_long     = 1'b0;
        m_count    = 8'd0;
        last_press = -1000000;
    endtask

    task automatic model_edge(input bit b);
        bit run_ok;
        bit was_level;
        int sz;
        hq.push_back(b);
        if (hq.size() > DEB + 3) hq.delete(0);
        n_edge++;
        sz = int'(hq.size());
        // The filter sees btn_in from two edges ago; it needs DEB+1 of
        // those samples in a row at the opposite level.
        run_ok = (sz >= DEB + 3);
        for (int j = 0; j <= DEB; j++) begin
            if (run_ok && (hq[sz - 3 - j] == m_level)) run_ok = 1'b0;
        end
        was_level = m_level;
        m_press = run_ok && !m_level;
        m_rel   = run_ok &&  m_level;
`ifdef LONG_PRESS_EN
        m_long  = was_level && ((n_edge - last_press) == LONG);
`else
        m_long  = 1'b0;
`endif
        if (m_press) begin
            m_level    = 1'b1;
            m_count    = m_count + 8'd1;
            last_press = n_edge;
        end
        if (m_rel) m_level = 1'b0;
    endtask

    task automatic compare_all();
        check("btn_level",     {31'd0, bus.btn_level},     {31'd0, m_level});
        check("press_pulse",   {31'd0, bus.press_pulse},   {31'd0, m_press});
        check("release_pulse", {31'd0, bus.release_pulse}, {31'd0, m_rel});
        check("long_pulse",    {31'd0, bus.long_pulse},    {31'd0, m_long});
        check("press_count",   {24'd0, bus.press_count},   {24'd0, m_count});
        if (bus.press_pulse === 1'b1) begin
            seen_press = n_edge;
            if (bus.press_count === 8'd0) wrap_seen = 1'b1;
        end
        if (bus.release_pulse === 1'b1) seen_release = n_edge;
        if (bus.long_pulse === 1'b1) begin
            seen_long = n_edge;
            long_hits++;
        end
    endtask

    // One clock: drive btn_in, take the edge, then compare 1 time unit later.
    task automatic step(input bit b);
        bus.btn_in = b;
        @(posedge clk);
        model_edge(b);
        #1;
        compare_all();
    endtask

    task automatic clear_seen();
        seen_press   = -1;
        seen_release = -1;
        seen_long    = -1;
        long_hits    = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_level"}, {31'd0, bus.btn_level},     32'd0);
        check({tag, "_press"}, {31'd0, bus.press_pulse},   32'd0);
        check({tag, "_rel"},   {31'd0, bus.release_pulse}, 32'd0);
        check({tag, "_long"},  {31'd0, bus.long_pulse},    32'd0);
        check({tag, "_count"}, {24'd0, bus.press_count},   32'd0);
    endtask

    initial begin
        int k;
        bus.btn_in = 1'b0;
        rst_n      = 1'b0;
        wrap_seen  = 1'b0;
        model_reset();
        clear_seen();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Clean press: 30 cycles high, then release.
        repeat (5) step(1'b0);
        clear_seen();
        k = n_edge + 1;
        repeat (30) step(1'b1);
        check("clean_press_lat", seen_press - k, 2 + DEB);
        check("clean_count", {24'd0, bus.press_count}, 32'd1);
`ifdef LONG_PRESS_EN
        check("clean_long_lat", seen_long - seen_press, LONG);
        check("clean_long_once", long_hits, 1);
`else
        check("clean_long_none", long_hits, 0);
`endif
        k = n_edge + 1;
        repeat (12) step(1'b0);
        check("clean_release_lat", seen_release - k, 2 + DEB);

        // Bounce shorter than the debounce window.
        clear_seen();
        repeat (3) step(1'b1);
        step(1'b0);
        repeat (3) step(1'b1);
        repeat (10) step(1'b0);
        check("bounce_no_press", seen_press, -1);
        check("bounce_count", {24'd0, bus.press_count}, 32'd1);

        // Release bounce while held must not restart the hold timer.
        clear_seen();
        repeat (10) step(1'b1);
        repeat (2) step(1'b0);
        repeat (20) step(1'b1);
        check("rbounce_no_release", seen_release, -1);
        check("rbounce_level", {31'd0, bus.btn_level}, 32'd1);
`ifdef LONG_PRESS_EN
        check("rbounce_long_lat", seen_long - seen_press, LONG);
`else
        check("rbounce_long_none", long_hits, 0);
`endif
        repeat (12) step(1'b0);

        // 256 more presses: the count passes through 0 and ends where it began.
        wrap_seen = 1'b0;
        for (int p = 0; p < 256; p++) begin
            repeat ($urandom_range(5, 10)) step(1'b1);
            repeat ($urandom_range(5, 10)) step(1'b0);
        end
        check("wrap_zero_seen", {31'd0, wrap_seen}, 32'd1);
        check("wrap_count", {24'd0, bus.press_count}, 32'd2);

        // Reset while held: outputs clear at once, then a fresh press.
        repeat (12) step(1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clear_seen();
        k = n_edge + 1;
        repeat (10) step(1'b1);
        check("midrst_press_lat", seen_press - k, 2 + DEB);
        check("midrst_count", {24'd0, bus.press_count}, 32'd1);
        repeat (10) step(1'b0);

        // Random activity: mostly short bounces, some long stable runs.
        for (int r = 0; r < 400; r++) begin
            bit v;
            int len;
            v   = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 24))
                                              : int'($urandom_range(1, 6));
            repeat (len) step(v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
